spi_slave: RTL and testbench

SPI slave (CPOL = 0, CPHA = 0, LSB first, 8-bit frames) that receives bytes from the SPI master and returns one byte per frame on MISO. The block runs entirely on the system clock: it oversamples and synchronizes `spi_sclk`, `spi_cs_n` and `spi_mosi`, then detects edges in the `sys_clk` domain. It sits on the peripheral side of the SPI link, with a byte-wide user interface toward local logic.

---
 rtl/spi_slave_if.sv | 23 ++
 rtl/spi_slave.sv | 139 +++++++++++++
 tb/tb_spi_slave.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/spi_slave_if.sv
// rtl/spi_slave_if.sv - user byte interface and SPI pins of spi_slave
interface spi_slave_if;
    logic [7:0] tx_data;
    logic       tx_load;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       spi_sclk;
    logic       spi_cs_n;
    logic       spi_mosi;
    logic       spi_miso;

    modport slave (
        input  tx_data, tx_load, spi_sclk, spi_cs_n, spi_mosi,
        output tx_ready, rx_data, rx_valid, frame_err, spi_miso
    );

    modport master (
        output tx_data, tx_load, spi_sclk, spi_cs_n, spi_mosi,
        input  tx_ready, rx_data, rx_valid, frame_err, spi_miso
    );
endinterface

// File: rtl/spi_slave.sv
// rtl/spi_slave.sv - oversampled SPI slave, mode 0, LSB first, 8-bit frames
module spi_slave #(
    parameter int   SYNC_STAGES = 2,
    parameter logic IDLE_MISO   = 1'b0
) (
    input  logic        sys_clk,
    input  logic        sys_reset_n,
    spi_slave_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE, WAIT_CS} state_t;

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   sclk_hist;
    logic                   cs_hist;

    // Registered edge flags and the MOSI sample that travels with them
    logic sclk_rise;
    logic sclk_fall;
    logic cs_fall;
    logic cs_rise;
    logic mosi_s;

    state_t     state;
    logic [3:0] bit_cnt;
    logic [7:0] tx_buf;
    logic [7:0] tx_shift;
    logic [7:0] rx_shift;
    logic [7:0] rx_data_q;
    logic       rx_valid_q;
    logic       frame_err_q;
    logic       miso_q;

    // Synchronizer chains; CS chain rests at its deselected level
    always_ff @(posedge sys_clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            sclk_sync <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], bus.spi_sclk};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], bus.spi_cs_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.spi_mosi};
        end
    end

    // Edge detection against a history flop; MOSI registered alongside so it aligns with sclk_rise
    always_ff @(posedge sys_clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            sclk_hist <= 1'b0;
            cs_hist   <= 1'b1;
            sclk_rise <= 1'b0;
            sclk_fall <= 1'b0;
            cs_fall   <= 1'b0;
            cs_rise   <= 1'b0;
            mosi_s    <= 1'b0;
        end else begin
            sclk_hist <= sclk_sync[SYNC_STAGES-1];
            cs_hist   <= cs_sync[SYNC_STAGES-1];
            sclk_rise <= sclk_sync[SYNC_STAGES-1] & ~sclk_hist;
            sclk_fall <= ~sclk_sync[SYNC_STAGES-1] & sclk_hist;
            cs_fall   <= ~cs_sync[SYNC_STAGES-1] & cs_hist;
            cs_rise   <= cs_sync[SYNC_STAGES-1] & ~cs_hist;
            mosi_s    <= mosi_sync[SYNC_STAGES-1];
        end
    end

    // Frame FSM; rx_data/rx_valid are written on the 8th rise so the pulse is high while in DONE
    always_ff @(posedge sys_clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            tx_buf      <= '0;
            tx_shift    <= '0;
            rx_shift    <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            miso_q      <= IDLE_MISO;
        end else begin
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            case (state)
                IDLE: begin
                    miso_q  <= IDLE_MISO;
                    bit_cnt <= '0;
                    if (bus.tx_load) begin
                        tx_buf <= bus.tx_data;
                    end
                    if (cs_fall) begin
                        tx_shift <= tx_buf;
                        miso_q   <= tx_buf[0];
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (cs_rise) begin
                        frame_err_q <= 1'b1;
                        bit_cnt     <= '0;
                        miso_q      <= IDLE_MISO;
                        state       <= IDLE;
                    end else if (sclk_rise) begin
                        rx_shift[bit_cnt[2:0]] <= mosi_s;
                        bit_cnt                <= bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            rx_data_q  <= {mosi_s, rx_shift[6:0]};
                            rx_valid_q <= 1'b1;
                            state      <= DONE;
                        end
                    end else if (sclk_fall && bit_cnt >= 4'd1 && bit_cnt <= 4'd7) begin
                        miso_q <= tx_shift[bit_cnt[2:0]];
                    end
                end
                DONE: begin
                    if (cs_rise) begin
                        miso_q <= IDLE_MISO;
                        state  <= IDLE;
                    end else begin
                        state <= WAIT_CS;
                    end
                end
                WAIT_CS: begin
                    if (cs_rise) begin
                        miso_q <= IDLE_MISO;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.tx_ready  = (state == IDLE);
    assign bus.rx_data   = rx_data_q;
    assign bus.rx_valid  = rx_valid_q;
    assign bus.frame_err = frame_err_q;
    assign bus.spi_miso  = miso_q;
endmodule

// File: tb/tb_spi_slave.sv
// tb/tb_spi_slave.sv - self-checking bench for spi_slave
module tb_spi_slave;
    localparam int   SYNC_STAGES = 2;
    localparam logic IDLE_MISO   = 1'b0;
    localparam int   HALF        = SYNC_STAGES + 3;
    localparam int   CS_GAP      = SYNC_STAGES + 8;

    typedef struct {
        logic       load;
        logic [7:0] tx;
        logic [7:0] mosi;
        int         nclk;
        logic       mid_load;
        logic [7:0] exp_miso;
        logic [7:0] exp_rx;
        int         exp_valid;
        int         exp_err;
    } vec_t;

    logic sys_clk = 1'b0;
    logic sys_reset_n = 1'b0;
    spi_slave_if bus();

    spi_slave #(.SYNC_STAGES(SYNC_STAGES), .IDLE_MISO(IDLE_MISO)) dut (
        .sys_clk     (sys_clk),
        .sys_reset_n (sys_reset_n),
        .bus         (bus)
    );

    always #5 sys_clk = ~sys_clk;

    int         n_checks = 0;
    int         n_pass = 0;
    int         valid_cnt = 0;
    int         err_cnt = 0;
    logic [7:0] valid_data = 8'h00;
    logic [7:0] model_tx = 8'h00;
    logic [7:0] model_rx = 8'h00;

    always @(negedge sys_clk) begin
        if (bus.rx_valid === 1'b1) begin
            valid_cnt++;
            valid_data = bus.rx_data;
        end
        if (bus.frame_err === 1'b1) begin
            err_cnt++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic load_tx(input logic [7:0] v);
        @(negedge sys_clk);
        bus.tx_data = v;
        bus.tx_load = 1'b1;
        @(negedge sys_clk);
        bus.tx_load = 1'b0;
    endtask

    task automatic bit_cycle(input logic mb, output logic sb);
        bus.spi_mosi = mb;
        repeat (HALF) @(negedge sys_clk);
        sb = bus.spi_miso;
        bus.spi_sclk = 1'b1;
        repeat (HALF) @(negedge sys_clk);
        bus.spi_sclk = 1'b0;
    endtask

    task automatic run_frame(input logic [7:0] mosi_byte, input int nclk, input logic mid_load,
                             output logic [15:0] miso_bits);
        logic b;
        logic [3:0] idx;
        miso_bits = '0;
        @(negedge sys_clk);
        bus.spi_cs_n = 1'b0;
        for (int i = 0; i < nclk; i++) begin
            idx = 4'(i);
            bit_cycle((i < 8) ? mosi_byte[idx[2:0]] : 1'b0, b);
            miso_bits[idx] = b;
            if (mid_load && i == 3) begin
                check("tx_ready_mid", 32'(bus.tx_ready), 32'd0);
                load_tx(8'h55);
            end
        end
        repeat (HALF) @(negedge sys_clk);
        bus.spi_cs_n = 1'b1;
        repeat (CS_GAP) @(negedge sys_clk);
    endtask

    task automatic do_frame(input vec_t v);
        logic [15:0] bits;
        logic [7:0]  mask;
        int          v0;
        int          e0;
        if (v.load) load_tx(v.tx);
        v0 = valid_cnt;
        e0 = err_cnt;
        run_frame(v.mosi, v.nclk, v.mid_load, bits);
        mask = 8'h00;
        for (int i = 0; i < 8; i++) if (i < v.nclk) mask[i] = 1'b1;
        check("miso_byte", 32'(bits[7:0] & mask), 32'(v.exp_miso & mask));
        for (int i = 8; i < v.nclk; i++) check("miso_hold", 32'(bits[i]), 32'(v.exp_miso[7]));
        check("rx_valid_cnt", 32'(valid_cnt - v0), 32'(v.exp_valid));
        check("frame_err_cnt", 32'(err_cnt - e0), 32'(v.exp_err));
        check("rx_data", 32'(bus.rx_data), 32'(v.exp_rx));
        check("tx_ready_after", 32'(bus.tx_ready), 32'd1);
        if (v.exp_valid > 0) check("rx_valid_data", 32'(valid_data), 32'(v.exp_rx));
    endtask

    vec_t tbl[8];

    initial begin
        vec_t       rv;
        logic       b;
        int         v0;

        tbl[0] = '{1'b1, 8'hA5, 8'h3C, 8,  1'b0, 8'hA5, 8'h3C, 1, 0};
        tbl[1] = '{1'b1, 8'h01, 8'h80, 8,  1'b0, 8'h01, 8'h80, 1, 0};
        tbl[2] = '{1'b1, 8'hFE, 8'h7F, 8,  1'b0, 8'hFE, 8'h7F, 1, 0};
        tbl[3] = '{1'b0, 8'h00, 8'h12, 8,  1'b0, 8'hFE, 8'h12, 1, 0};
        tbl[4] = '{1'b0, 8'h00, 8'h34, 8,  1'b1, 8'hFE, 8'h34, 1, 0};
        tbl[5] = '{1'b0, 8'h00, 8'hAA, 5,  1'b0, 8'hFE, 8'h34, 0, 1};
        tbl[6] = '{1'b0, 8'h00, 8'hC3, 8,  1'b0, 8'hFE, 8'hC3, 1, 0};
        tbl[7] = '{1'b0, 8'h00, 8'h69, 10, 1'b0, 8'hFE, 8'h69, 1, 0};

        bus.tx_data  = 8'h00;
        bus.tx_load  = 1'b0;
        bus.spi_sclk = 1'b0;
        bus.spi_cs_n = 1'b1;
        bus.spi_mosi = 1'b0;
        repeat (4) @(negedge sys_clk);
        sys_reset_n = 1'b1;
        repeat (4) @(negedge sys_clk);

        check("rst_miso", 32'(bus.spi_miso), 32'(IDLE_MISO));
        check("rst_rx_data", 32'(bus.rx_data), 32'h00);
        check("rst_rx_valid", 32'(bus.rx_valid), 32'd0);
        check("rst_frame_err", 32'(bus.frame_err), 32'd0);
        check("rst_tx_ready", 32'(bus.tx_ready), 32'd1);

        for (int i = 0; i < 8; i++) do_frame(tbl[i]);

        model_tx = 8'hFE;
        model_rx = 8'h69;
        for (int i = 0; i < 16; i++) begin
            rv.load     = 1'($urandom_range(0, 1));
            rv.tx       = 8'($urandom);
            rv.mosi     = 8'($urandom);
            rv.nclk     = int'($urandom_range(3, 10));
            rv.mid_load = 1'b0;
            if (rv.load) model_tx = rv.tx;
            if (rv.nclk >= 8) model_rx = rv.mosi;
            rv.exp_miso  = model_tx;
            rv.exp_rx    = model_rx;
            rv.exp_valid = (rv.nclk >= 8) ? 1 : 0;
            rv.exp_err   = (rv.nclk >= 8) ? 0 : 1;
            do_frame(rv);
        end

        load_tx(8'h3A);
        v0 = valid_cnt;
        @(negedge sys_clk);
        bus.spi_cs_n = 1'b0;
        for (int i = 0; i < 3; i++) bit_cycle(1'b1, b);
        repeat (2) @(negedge sys_clk);
        sys_reset_n = 1'b0;
        #1;
        check("midrst_miso", 32'(bus.spi_miso), 32'(IDLE_MISO));
        check("midrst_rx_data", 32'(bus.rx_data), 32'h00);
        check("midrst_rx_valid", 32'(bus.rx_valid), 32'd0);
        check("midrst_frame_err", 32'(bus.frame_err), 32'd0);
        check("midrst_tx_ready", 32'(bus.tx_ready), 32'd1);
        bus.spi_cs_n = 1'b1;
        bus.spi_sclk = 1'b0;
        repeat (4) @(negedge sys_clk);
        sys_reset_n = 1'b1;
        repeat (CS_GAP) @(negedge sys_clk);
        check("midrst_no_valid", 32'(valid_cnt - v0), 32'd0);

        rv = '{1'b0, 8'h00, 8'h5A, 8, 1'b0, 8'h00, 8'h5A, 1, 0};
        do_frame(rv);
        rv = '{1'b1, 8'h96, 8'hE1, 8, 1'b0, 8'h96, 8'hE1, 1, 0};
        do_frame(rv);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
